// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush sequencer (slave).
// The datapath reports hazards here, and the sequencer returns its enables and performance counters.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_uses_rs;
    logic        ID_uses_rt;
    logic        ID_jump;
    logic        EX_Mem_rd;
    logic [4:0]  EX_wr_reg;
    logic        EX_branch_tkn;
    logic        EX_md_start;
    logic        cnt_clr;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        ID_EX_hold;
    logic        EX_MEM_flush;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_jump,
        output EX_Mem_rd, EX_wr_reg, EX_branch_tkn, EX_md_start, cnt_clr,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, ID_EX_hold,
        input  EX_MEM_flush, md_busy, md_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, ID_jump,
        input  EX_Mem_rd, EX_wr_reg, EX_branch_tkn, EX_md_start, cnt_clr,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, ID_EX_hold,
        output EX_MEM_flush, md_busy, md_done, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational hazard response with priority,
// a two-state FSM that stalls fetch during a multi-cycle mult/div, and stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_md_cnt;
    logic [CNT_W-1:0]   w_next_md_cnt;
    logic [31:0]        r_stall_cnt;
    logic [15:0]        r_flush_cnt;

    logic w_load_use;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_id_ex_hold;
    logic w_ex_mem_flush;
    logic w_md_busy;
    logic w_md_done;

    // A load in EX whose non-zero destination feeds a source that ID actually reads.
    function automatic logic load_use_hit(
        input logic       ex_load,
        input logic [4:0] ex_wr,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        logic rs_hit;
        logic rt_hit;
        rs_hit = uses_rs && (ex_wr == id_rs);
        rt_hit = uses_rt && (ex_wr == id_rt);
        return ex_load && (ex_wr != 5'd0) && (rs_hit || rt_hit);
    endfunction

    assign w_load_use = load_use_hit(hz.EX_Mem_rd, hz.EX_wr_reg, hz.ID_rs, hz.ID_rt,
                                     hz.ID_uses_rs, hz.ID_uses_rt);

    // Next-state and hazard outputs; every output is forced low while reset is asserted.
    always_comb begin
        w_next_state   = r_state;
        w_next_md_cnt  = r_md_cnt;
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_md_busy      = 1'b0;
        w_md_done      = 1'b0;
        if (reset) begin
            w_next_state  = ST_RUN;
            w_next_md_cnt = {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    if (hz.EX_branch_tkn) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (hz.EX_md_start) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_hold  = 1'b1;
                        w_md_busy     = 1'b1;
                        // A single-cycle unit finishes in its start cycle and never leaves RUN.
                        if (MD_LATENCY == 1) begin
                            w_md_done = 1'b1;
                        end else begin
                            w_ex_mem_flush = 1'b1;
                            w_next_md_cnt  = CNT_W'(MD_LATENCY - 1);
                            w_next_state   = ST_MD_WAIT;
                        end
                    end else if (w_load_use) begin
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_id_ex_flush = 1'b1;
                    end else if (hz.ID_jump) begin
                        w_if_id_flush = 1'b1;
                    end else begin
                        w_if_id_flush = 1'b0;
                    end
                end
                ST_MD_WAIT: begin
                    w_id_ex_hold  = 1'b1;
                    w_md_busy     = 1'b1;
                    w_next_md_cnt = r_md_cnt - CNT_W'(1);
                    if (r_md_cnt == CNT_W'(1)) begin
                        w_md_done    = 1'b1;
                        w_next_state = ST_RUN;
                    end else begin
                        w_ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                    w_next_state  = ST_RUN;
                    w_next_md_cnt = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state and mult/div down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_md_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_next_md_cnt;
        end
    end

    // Performance counters: stall count wraps, flush count saturates, clear beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else if (hz.cnt_clr) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!w_pc_write) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_if_id_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign hz.PC_write     = w_pc_write;
    assign hz.IF_ID_write  = w_if_id_write;
    assign hz.IF_ID_flush  = w_if_id_flush;
    assign hz.ID_EX_flush  = w_id_ex_flush;
    assign hz.ID_EX_hold   = w_id_ex_hold;
    assign hz.EX_MEM_flush = w_ex_mem_flush;
    assign hz.md_busy      = w_md_busy;
    assign hz.md_done      = w_md_done;
    assign hz.stall_cnt    = r_stall_cnt;
    assign hz.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: inputs change on the falling edge, outputs are
// sampled 1 time unit later, so combinational responses and counter updates are both stable.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] outs;
    logic [7:0] exp_outs;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl #(.MD_LATENCY(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, ID_EX_hold, EX_MEM_flush, md_busy, md_done}
    assign outs = {hz_if.PC_write, hz_if.IF_ID_write, hz_if.IF_ID_flush, hz_if.ID_EX_flush,
                   hz_if.ID_EX_hold, hz_if.EX_MEM_flush, hz_if.md_busy, hz_if.md_done};

    task automatic drive_idle();
        hz_if.ID_rs         = 5'd0;
        hz_if.ID_rt         = 5'd0;
        hz_if.ID_uses_rs    = 1'b0;
        hz_if.ID_uses_rt    = 1'b0;
        hz_if.ID_jump       = 1'b0;
        hz_if.EX_Mem_rd     = 1'b0;
        hz_if.EX_wr_reg     = 5'd0;
        hz_if.EX_branch_tkn = 1'b0;
        hz_if.EX_md_start   = 1'b0;
        hz_if.cnt_clr       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        @(negedge clk); #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL reset_outs got %h exp %h", outs, 8'h00);
        end
        checks++;
        if (hz_if.stall_cnt !== 32'd0 || hz_if.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", hz_if.stall_cnt, hz_if.flush_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (outs !== 8'hC0) begin
                errors++; $display("FAIL idle_run[%0d] got %h exp %h", i, outs, 8'hC0);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (hz_if.stall_cnt !== 32'd0 || hz_if.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL idle_cnts got %0d/%0d exp 0/0", hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        hz_if.EX_Mem_rd = 1'b1; hz_if.EX_wr_reg = 5'd5; hz_if.ID_rs = 5'd5;
        hz_if.ID_uses_rs = 1'b1; hz_if.ID_jump = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h10) begin
            errors++; $display("FAIL load_use_rs got %h exp %h", outs, 8'h10);
        end
        @(negedge clk);
        hz_if.EX_wr_reg = 5'd0; hz_if.ID_rs = 5'd0;
        #1;
        checks++;
        if (outs !== 8'hE0) begin
            errors++; $display("FAIL load_use_r0_jump got %h exp %h", outs, 8'hE0);
        end
        @(negedge clk);
        drive_idle();
        hz_if.EX_Mem_rd = 1'b1; hz_if.EX_wr_reg = 5'd7; hz_if.ID_rt = 5'd7; hz_if.ID_uses_rt = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h10) begin
            errors++; $display("FAIL load_use_rt got %h exp %h", outs, 8'h10);
        end
        @(negedge clk);
        hz_if.ID_uses_rt = 1'b0;
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++; $display("FAIL load_use_unread got %h exp %h", outs, 8'hC0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (hz_if.stall_cnt !== 32'd2 || hz_if.flush_cnt !== 16'd1) begin
            errors++; $display("FAIL load_use_cnts got %0d/%0d exp 2/1", hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        hz_if.EX_branch_tkn = 1'b1; hz_if.EX_Mem_rd = 1'b1; hz_if.EX_wr_reg = 5'd9;
        hz_if.ID_rs = 5'd9; hz_if.ID_uses_rs = 1'b1; hz_if.ID_jump = 1'b1;
        #1;
        checks++;
        if (outs !== 8'hF0) begin
            errors++; $display("FAIL branch_over_load_use got %h exp %h", outs, 8'hF0);
        end
        @(negedge clk);
        drive_idle();
        hz_if.EX_branch_tkn = 1'b1; hz_if.EX_md_start = 1'b1;
        #1;
        checks++;
        if (outs !== 8'hF0) begin
            errors++; $display("FAIL branch_over_md got %h exp %h", outs, 8'hF0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++; $display("FAIL branch_stays_run got %h exp %h", outs, 8'hC0);
        end
        checks++;
        if (hz_if.stall_cnt !== 32'd2 || hz_if.flush_cnt !== 16'd3) begin
            errors++; $display("FAIL branch_cnts got %0d/%0d exp 2/3", hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_md_stall();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) begin
                hz_if.EX_md_start = 1'b1; hz_if.EX_Mem_rd = 1'b1; hz_if.EX_wr_reg = 5'd5;
                hz_if.ID_rs = 5'd5; hz_if.ID_uses_rs = 1'b1;
            end else begin
                hz_if.EX_md_start = 1'b0; hz_if.EX_branch_tkn = 1'b1; hz_if.ID_jump = 1'b1;
            end
            #1;
            exp_outs = (i == 31) ? 8'h0B : 8'h0E;
            checks++;
            if (outs !== exp_outs) begin
                errors++; $display("FAIL md_cycle[%0d] got %h exp %h", i, outs, exp_outs);
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (outs !== 8'hC0) begin
            errors++; $display("FAIL md_back_to_run got %h exp %h", outs, 8'hC0);
        end
        checks++;
        if (hz_if.stall_cnt !== 32'd34 || hz_if.flush_cnt !== 16'd3) begin
            errors++; $display("FAIL md_cnts got %0d/%0d exp 34/3", hz_if.stall_cnt, hz_if.flush_cnt);
        end
    endtask

    task automatic test_md_reset();
        @(negedge clk);
        hz_if.EX_md_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            hz_if.EX_md_start = 1'b0;
            #1;
            checks++;
            if (outs !== 8'h0E) begin
                errors++; $display("FAIL md_wait[%0d] got %h exp %h", i, outs, 8'h0E);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++; $display("FAIL md_reset_outs got %h exp %h", outs, 8'h00);
        end
        checks++;
        if (hz_if.stall_cnt !== 32'd0 || hz_if.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL md_reset_cnts got %0d/%0d exp 0/0", hz_if.stall_cnt, hz_if.flush_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 8'hC0) begin
                errors++; $display("FAIL md_reset_run[%0d] got %h exp %h", i, outs, 8'hC0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_sat();
        hz_if.ID_jump = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (hz_if.flush_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL flush_preload got %h exp %h", hz_if.flush_cnt, 16'hFFFE);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (hz_if.flush_cnt !== 16'hFFFF) begin
                errors++; $display("FAIL flush_sat[%0d] got %h exp %h", i, hz_if.flush_cnt, 16'hFFFF);
            end
        end
        @(negedge clk);
        hz_if.cnt_clr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (hz_if.flush_cnt !== 16'd0 || hz_if.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL flush_clr got %h/%0d exp 0/0", hz_if.flush_cnt, hz_if.stall_cnt);
        end
        @(negedge clk);
        hz_if.cnt_clr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hz_if.flush_cnt !== 16'd1) begin
            errors++; $display("FAIL flush_after_clr got %h exp %h", hz_if.flush_cnt, 16'd1);
        end
        @(negedge clk);
        drive_idle();
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_md_stall();
        test_md_reset();
        test_flush_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
